alu_submodule_sub: RTL and testbench

Registered WIDTH-bit (default 16) two's-complement subtractor slice of the ALU.
- Computes Answer = A - B with status flags.
- Captures the result one clock after a valid input.
- Sits beside the other ALU submodules, and the ALU result mux selects its output.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_sub_core.sv | 26 ++
 rtl/alu_submodule_sub.sv | 77 +++++++
 tb/tb_alu_submodule_sub.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Types and constants shared by the ALU submodules: the default datapath
// width, the word type and the status-flag bundle every submodule reports.
package alu_pkg;

    localparam int ALU_WIDTH = 16;

    typedef logic [ALU_WIDTH-1:0] alu_word_t;

    typedef struct packed {
        logic zero;
        logic negative;
        logic borrow;
        logic overflow;
    } alu_flags_t;

    // Most positive / most negative two's-complement value of a given width
    function automatic logic [ALU_WIDTH-1:0] alu_signed_max();
        return {1'b0, {(ALU_WIDTH-1){1'b1}}};
    endfunction

    function automatic logic [ALU_WIDTH-1:0] alu_signed_min();
        return {1'b1, {(ALU_WIDTH-1){1'b0}}};
    endfunction

endpackage

// File: rtl/alu_sub_core.sv
// Combinational ripple-borrow subtractor: diff = a - b, with unsigned borrow
// out of the MSB and two's-complement overflow.
module alu_sub_core #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow
);

    logic [WIDTH:0] bchain;

    assign bchain[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fs
        assign diff[i]       = a[i] ^ b[i] ^ bchain[i];
        assign bchain[i+1]   = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bchain[i]);
    end

    assign borrow   = bchain[WIDTH];
    // Operands of opposite sign whose result takes the subtrahend's sign
    assign overflow = (a[WIDTH-1] ^ b[WIDTH-1]) & (diff[WIDTH-1] ^ a[WIDTH-1]);

endmodule

// File: rtl/alu_submodule_sub.sv
// Registered subtractor slice of the ALU: Answer = A - B plus status flags,
// one cycle after in_valid. Define SUB_SATURATE_EN to clamp on signed overflow.
module alu_submodule_sub
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Answer,
    output logic             out_valid,
    output logic             zero,
    output logic             negative,
    output logic             borrow,
    output logic             overflow
);

    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] result;
    logic             core_borrow;
    logic             core_overflow;

    logic [WIDTH-1:0] answer_q;
    logic             valid_q;
    alu_flags_t       flags_q;

    alu_sub_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a        (A),
        .b        (B),
        .diff     (diff),
        .borrow   (core_borrow),
        .overflow (core_overflow)
    );

`ifdef SUB_SATURATE_EN
    // Clamp toward the side the true result lies on, which follows A's sign
    always_comb begin
        result = diff;
        if (core_overflow) begin
            result = A[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign result = diff;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            answer_q <= '0;
            valid_q  <= 1'b0;
            flags_q  <= '0;
        end else if (in_valid) begin
            answer_q         <= result;
            valid_q          <= 1'b1;
            flags_q.zero     <= (result == '0);
            flags_q.negative <= result[WIDTH-1];
            flags_q.borrow   <= core_borrow;
            flags_q.overflow <= core_overflow;
        end else begin
            valid_q <= 1'b0;
        end
    end

    assign Answer    = answer_q;
    assign out_valid = valid_q;
    assign zero      = flags_q.zero;
    assign negative  = flags_q.negative;
    assign borrow    = flags_q.borrow;
    assign overflow  = flags_q.overflow;

endmodule

// File: tb/tb_alu_submodule_sub.sv
// Scoreboard bench for alu_submodule_sub: directed vectors push expected
// results; a negedge monitor pops and compares whenever out_valid is high.
module tb_alu_submodule_sub;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] A = '0;
    logic [15:0] B = '0;
    logic [15:0] Answer;
    logic        out_valid, zero, negative, borrow, overflow;

    typedef struct {
        string       name;
        logic [15:0] ans;
        logic        z, n, b, o;
    } exp_t;

    exp_t q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    alu_submodule_sub #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .Answer    (Answer),
        .out_valid (out_valid),
        .zero      (zero),
        .negative  (negative),
        .borrow    (borrow),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Packed view: {out_valid, Answer, zero, negative, borrow, overflow}
    function automatic logic [20:0] dut_view();
        return {out_valid, Answer, zero, negative, borrow, overflow};
    endfunction

    task automatic check(input string nm, input logic [20:0] act, input logic [20:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got v=%0b ans=%h znbo=%b, expected v=%0b ans=%h znbo=%b",
                      nm, act[20], act[19:4], act[3:0], req[20], req[19:4], req[3:0]);
    endtask

    always @(negedge clk) begin
        if (out_valid) begin
            if (q.size() == 0) begin
                check("unexpected_valid", dut_view(), {1'b0, 20'h0});
            end else begin
                exp_t e;
                e = q.pop_front();
                check(e.name, dut_view(), {1'b1, e.ans, e.z, e.n, e.b, e.o});
            end
        end
    end

    task automatic issue(input string nm, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] ans, input logic z, input logic n,
                         input logic bw, input logic o);
        exp_t e;
        @(posedge clk);
        #1;
        A = a;
        B = b;
        in_valid = 1'b1;
        e.name = nm; e.ans = ans; e.z = z; e.n = n; e.b = bw; e.o = o;
        q.push_back(e);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        A = 16'($urandom);
        B = 16'($urandom);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_state", dut_view(), 21'h0);

        issue("15-10", 16'd15, 16'd10, 16'd5, 0, 0, 0, 0);
        issue("13-13", 16'd13, 16'd13, 16'd0, 1, 0, 0, 0);
        issue("5-8",   16'd5,  16'd8,  16'hFFFD, 0, 1, 1, 0);
        idle();
        @(posedge clk);
        @(negedge clk);
        check("hold_after_idle", dut_view(), {1'b0, 16'hFFFD, 4'b0110});

        issue("0-0",   16'h0000, 16'h0000, 16'h0000, 1, 0, 0, 0);
        issue("0-1",   16'h0000, 16'h0001, 16'hFFFF, 0, 1, 1, 0);
        issue("8000-8000", 16'h8000, 16'h8000, 16'h0000, 1, 0, 0, 0);
`ifdef SUB_SATURATE_EN
        issue("8000-1",    16'h8000, 16'h0001, 16'h8000, 0, 1, 0, 1);
        issue("7FFF-FFFF", 16'h7FFF, 16'hFFFF, 16'h7FFF, 0, 0, 1, 1);
        issue("8000-7FFF", 16'h8000, 16'h7FFF, 16'h8000, 0, 1, 0, 1);
`else
        issue("8000-1",    16'h8000, 16'h0001, 16'h7FFF, 0, 0, 0, 1);
        issue("7FFF-FFFF", 16'h7FFF, 16'hFFFF, 16'h8000, 0, 1, 1, 1);
        issue("8000-7FFF", 16'h8000, 16'h7FFF, 16'h0001, 0, 0, 0, 1);
`endif
        issue("1234-0234", 16'h1234, 16'h0234, 16'h1000, 0, 0, 0, 0);
        idle();
        repeat (3) @(posedge clk);

        // Back-to-back with reset on the second capture edge
        issue("b2b_15-10", 16'd15, 16'd10, 16'd5, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        A = 16'd13;
        B = 16'd13;
        in_valid = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("reset_mid_stream", dut_view(), 21'h0);

        repeat (4) @(posedge clk);
        @(negedge clk);
        n_total++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
